// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: FSM state encoding and digit limits.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   localparam int unsigned SEC_U_MAX = 9;
   localparam int unsigned SEC_T_MAX = 5;
   localparam int unsigned MIN_U_MAX = 9;
   localparam int unsigned MIN_T_MAX = 5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MAX; carry_out fires on the increment that rolls it back to 0.
module bcd_digit #(
   parameter int unsigned MAX = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc_in,
   output logic [3:0] q,
   output logic       carry_out
);

   localparam logic [3:0] QMAX = 4'(MAX);

   // Digit register; any out-of-range value collapses to 0 on the next increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (inc_in) begin
         q <= (q >= QMAX) ? 4'd0 : q + 4'd1;
      end
   end

   assign carry_out = inc_in & (q == QMAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch driven by rising edges of the divided clock, with run/pause, clear and lap hold.
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICKS_PER_COUNT = 1,
   parameter int unsigned PRE_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] digits,
   output logic        running,
   output logic        lap_active,
   output logic        wrap
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_COUNT - 1);

   state_t           state;
   logic             tick_prev;
   logic             rise;
   logic             counting;
   logic             inc;
   logic             inc_en;
   logic [PRE_W-1:0] pre;
   logic [15:0]      count;
   logic [15:0]      lap_reg;
   logic [3:0]       sec_u, sec_t, min_u, min_t;
   logic             c_sec_u, c_sec_t, c_min_u, c_min_t;

   assign rise     = tick_in & ~tick_prev;
   assign counting = (state == RUN) || (state == LAP);
   assign inc      = rise & counting & (pre == PRE_LAST);
   // clear wins over any increment landing in the same cycle
   assign inc_en   = inc & ~clear;

   // Previous tick level; resets high so a tick already high at release is not an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_prev <= 1'b1;
      end else begin
         tick_prev <= tick_in;
      end
   end

   // Prescaler: divides tick edges down to count increments, frozen outside RUN/LAP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre <= '0;
      end else if (clear) begin
         pre <= '0;
      end else if (rise && counting) begin
         pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end
   end

   bcd_digit #(.MAX(SEC_U_MAX)) u_sec_u (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .inc_in    (inc_en),
      .q         (sec_u),
      .carry_out (c_sec_u)
   );

   bcd_digit #(.MAX(SEC_T_MAX)) u_sec_t (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .inc_in    (c_sec_u),
      .q         (sec_t),
      .carry_out (c_sec_t)
   );

   bcd_digit #(.MAX(MIN_U_MAX)) u_min_u (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .inc_in    (c_sec_t),
      .q         (min_u),
      .carry_out (c_min_u)
   );

   bcd_digit #(.MAX(MIN_T_MAX)) u_min_t (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .inc_in    (c_min_u),
      .q         (min_t),
      .carry_out (c_min_t)
   );

   assign count = {min_t, min_u, sec_t, sec_u};

   // Control FSM with registered status outputs and the lap snapshot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         lap_reg    <= 16'h0000;
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         wrap <= c_min_t;
         if (clear) begin
            state      <= IDLE;
            lap_reg    <= 16'h0000;
            running    <= 1'b0;
            lap_active <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_stop) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (start_stop) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (lap) begin
                     // snapshot is the value before this cycle's increment
                     state      <= LAP;
                     lap_active <= 1'b1;
                     lap_reg    <= count;
                  end
               end
               LAP: begin
                  if (start_stop) begin
                     state      <= PAUSE;
                     running    <= 1'b0;
                     lap_active <= 1'b0;
                  end else if (lap) begin
                     state      <= RUN;
                     lap_active <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (start_stop) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // lap_active is a registered copy of (state == LAP), so the mux sees only registers
   assign digits = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench: table-driven cycle vectors through a scoreboard queue, two prescale settings.
module tb_bcd_stopwatch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick_in = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        lap = 1'b0;
   logic [15:0] digits, digits2;
   logic        running, running2, lap_active, lap_active2, wrap, wrap2;

   always #5 clk = ~clk;

   bcd_stopwatch #(.TICKS_PER_COUNT(1), .PRE_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .digits     (digits),
      .running    (running),
      .lap_active (lap_active),
      .wrap       (wrap)
   );

   bcd_stopwatch #(.TICKS_PER_COUNT(2), .PRE_W(8)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .digits     (digits2),
      .running    (running2),
      .lap_active (lap_active2),
      .wrap       (wrap2)
   );

   typedef struct {
      logic        r, t, s, c, l;
      logic [15:0] d;
      logic        run, la, w;
      logic        chk2;
      logic [15:0] d2;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   string sect = "reset";
   vec_t  sb[$];
   vec_t  tbl[$];

   task automatic chk(string what, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %h want %h", sect, what, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(int n);
      int m, s;
      m = (n % 3600) / 60;
      s = n % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   // Row: rst, tick, start_stop, clear, lap -> digits, running, lap_active, wrap after the edge.
   function automatic vec_t mk(logic r, logic t, logic s, logic c, logic l,
                               logic [15:0] d, logic run, logic la, logic w);
      vec_t v;
      v.r = r; v.t = t; v.s = s; v.c = c; v.l = l;
      v.d = d; v.run = run; v.la = la; v.w = w;
      v.chk2 = 1'b0; v.d2 = 16'h0000;
      return v;
   endfunction

   function automatic vec_t mk2(vec_t v, logic [15:0] d2);
      vec_t o;
      o = v;
      o.chk2 = 1'b1;
      o.d2 = d2;
      return o;
   endfunction

   task automatic drive(vec_t v);
      vec_t e;
      rst = v.r; tick_in = v.t; start_stop = v.s; clear = v.c; lap = v.l;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("digits", digits, e.d);
      chk("running", {15'd0, running}, {15'd0, e.run});
      chk("lap_active", {15'd0, lap_active}, {15'd0, e.la});
      chk("wrap", {15'd0, wrap}, {15'd0, e.w});
      if (e.chk2) begin
         chk("digits2", digits2, e.d2);
      end
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) drive(tbl[i]);
      tbl.delete();
   endtask

   task automatic bulk(logic t);
      rst = 1'b1; tick_in = t; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      run_tbl();

      // Start, then ten tick periods
      sect = "count10";
      tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 1, 0, 0));
      for (int i = 1; i <= 10; i++) begin
         tbl.push_back(mk(1, 1, 0, 0, 0, to_bcd(i), 1, 0, 0));
         tbl.push_back(mk(1, 0, 0, 0, 0, to_bcd(i), 1, 0, 0));
      end
      run_tbl();

      // Preload to 59:59 then roll over
      sect = "wrap";
      for (int i = 11; i <= 3599; i++) begin
         bulk(1'b1);
         bulk(1'b0);
      end
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h5959, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 1, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0001, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0001, 1, 0, 0));
      run_tbl();

      // Lap hold at 00:05 while counting continues underneath
      sect = "lap";
      tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 1, 0, 0));
      for (int i = 1; i <= 5; i++) begin
         tbl.push_back(mk(1, 1, 0, 0, 0, to_bcd(i), 1, 0, 0));
         tbl.push_back(mk(1, 0, 0, 0, 0, to_bcd(i), 1, 0, 0));
      end
      tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0005, 1, 1, 0));
      for (int i = 0; i < 3; i++) begin
         tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0005, 1, 1, 0));
         tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0005, 1, 1, 0));
      end
      tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0008, 1, 0, 0));
      run_tbl();

      // Pause coincident with a tick at 00:07: that tick still counts
      sect = "pause";
      tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 1, 0, 0));
      for (int i = 1; i <= 7; i++) begin
         tbl.push_back(mk(1, 1, 0, 0, 0, to_bcd(i), 1, 0, 0));
         tbl.push_back(mk(1, 0, 0, 0, 0, to_bcd(i), 1, 0, 0));
      end
      tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0008, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0008, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0008, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0008, 0, 0, 0));
      run_tbl();

      // Clear with coincident tick and lap while in LAP; then IDLE start ignores its tick
      sect = "clear";
      tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0008, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 16'h0008, 1, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0008, 1, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0008, 1, 1, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0001, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0001, 1, 0, 0));
      run_tbl();

      // Prescale by two on dut2, then mid-run reset with tick held high across release
      sect = "prescale";
      tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 1, 0, 0));
      for (int i = 1; i <= 5; i++) begin
         tbl.push_back(mk2(mk(1, 1, 0, 0, 0, to_bcd(i), 1, 0, 0), to_bcd(i / 2)));
         tbl.push_back(mk2(mk(1, 0, 0, 0, 0, to_bcd(i), 1, 0, 0), to_bcd(i / 2)));
      end
      tbl.push_back(mk2(mk(0, 1, 0, 0, 0, 16'h0000, 0, 0, 0), 16'h0000));
      tbl.push_back(mk2(mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0), 16'h0000));
      tbl.push_back(mk2(mk(1, 1, 1, 0, 0, 16'h0000, 1, 0, 0), 16'h0000));
      tbl.push_back(mk2(mk(1, 0, 0, 0, 0, 16'h0000, 1, 0, 0), 16'h0000));
      tbl.push_back(mk2(mk(1, 1, 0, 0, 0, 16'h0001, 1, 0, 0), 16'h0000));
      tbl.push_back(mk2(mk(1, 0, 0, 0, 0, 16'h0001, 1, 0, 0), 16'h0000));
      tbl.push_back(mk2(mk(1, 1, 0, 0, 0, 16'h0002, 1, 0, 0), 16'h0001));
      run_tbl();

      sect = "dut2_status";
      chk("running2", {15'd0, running2}, 16'd1);
      chk("lap_active2", {15'd0, lap_active2}, 16'd0);
      chk("wrap2", {15'd0, wrap2}, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- MM:SS stopwatch that consumes the divided clock produced by the upstream clock divider (clk_div, typically 1 Hz, same clk domain).
- Detects rising edges of the divided clock in the system clock domain and prescales them into count events.
- Advances a 4-digit BCD count under start/stop, clear and lap control.
- Feeds the downstream 7-segment scanner with packed BCD digits.

Parameters:
- TICKS_PER_COUNT, 1, number of tick_in rising edges per count increment (1..255).
- PRE_W, 8, prescaler counter width.

Ports:
- clk  input  1  system clock (50 MHz), same domain as tick_in source.
- rst  input  1  reset, synchronous, active-low.
- tick_in  input  1  divided clock level from the divider; only rising edges are used.
- start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes count and returns to IDLE.
- lap  input  1  single-cycle pulse; freezes or releases the displayed value.
- digits  output  16  {min_tens, min_units, sec_tens, sec_units}, BCD nibbles.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- wrap  output  1  one-cycle pulse when the count rolls 59:59 -> 00:00.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE; count, lap_reg and prescaler = 0.
  - tick_prev = 1, so no spurious edge is detected in the first cycle after reset.
  - Outputs: digits = 16'h0000, running = 0, lap_active = 0, wrap = 0.
- Edge detect: rise = tick_in & ~tick_prev (combinational); tick_prev <= tick_in every cycle.
- Prescaler:
  - Advances only on rise while in RUN or LAP.
  - On a rise with pre == TICKS_PER_COUNT-1: pre <= 0 and inc is asserted; otherwise pre <= pre+1.
  - Holds in PAUSE. Cleared by clear and by reset.
- Count chain:
  - Digit limits: sec_units 0-9, sec_tens 0-5, min_units 0-9, min_tens 0-5.
  - Carry ripples combinationally within the cycle.
  - 59:59 + inc -> 00:00, with wrap = 1 for exactly that one cycle.
- Latency: when TICKS_PER_COUNT = 1, the count updates at the first clk edge that samples tick_in = 1. digits reflects the new value one cycle after tick_in rises.
- FSM states: IDLE, RUN, PAUSE, LAP. The current state decides whether this cycle's inc is applied.
  - IDLE: start_stop -> RUN. A tick in the same cycle is not counted. lap is ignored.
  - RUN: start_stop -> PAUSE. A tick in the same cycle is counted. lap -> LAP, and lap_reg <= the count value before this cycle's increment.
  - LAP: counting continues; digits show lap_reg. lap -> RUN (digits live again). start_stop -> PAUSE (digits live).
  - PAUSE: start_stop -> RUN. lap is ignored. The count and prescaler hold.
- Priority within one cycle: clear > start_stop > lap.
  - clear from any state -> IDLE with count, lap_reg and prescaler zeroed. Any coincident inc is discarded and wrap = 0.
  - When start_stop and lap arrive together, lap is ignored.
- digits mux: lap_reg when state == LAP, else count.
  - All outputs are driven from registers.
  - No combinational path from any input to any output.
- Mid-operation reset: identical to power-on reset regardless of state. A pending tick edge is lost.
- Undefined digit codes (nibbles > limit) are unreachable. The digit sub-module forces any out-of-range value to 0 on its next inc.

Decomposition:
- Shared package stopwatch_pkg:
  - State encoding localparams (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3).
  - Digit limit constants SEC_U_MAX = 9, SEC_T_MAX = 5, MIN_U_MAX = 9, MIN_T_MAX = 5.
- Sub-module bcd_digit, instantiated 4 times:
  - Parameter MAX.
  - Ports: clk, rst, clr, inc_in, q[3:0], carry_out.
  - carry_out = inc_in & (q == MAX).
- Top level holds the edge detect, prescaler, FSM, lap_reg and output mux.

Test Plan:
- Reset, then start_stop pulse, then 10 tick_in periods (TICKS_PER_COUNT = 1) -> digits = 16'h0010, running = 1.
- Preload via 3599 ticks, then one more tick -> digits 16'h5959 -> 16'h0000, wrap high for exactly 1 cycle.
- RUN at 00:05, lap pulse, then 3 ticks -> digits held at 16'h0005, lap_active = 1. Second lap pulse -> digits = 16'h0008.
- start_stop coincident with a tick edge in RUN at 00:07 -> digits = 16'h0008, state PAUSE. Further ticks leave 16'h0008.
- clear coincident with a tick and lap in LAP -> next cycle digits = 16'h0000, running = 0, lap_active = 0, wrap = 0.
- TICKS_PER_COUNT = 2: start, 5 tick rises -> digits = 16'h0002, prescaler = 1. Assert rst low for 1 cycle -> all outputs 0. tick_in held high across the reset release produces no count.
